// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller between IF/ID and ID/EX.
// Detects load-use and branch-in-ID data hazards, sizes the stall to the
// required bubble count, and holds PC / IF/ID while bubbling ID/EX for
// the whole stall. A flush aborts a stall in progress. Also keeps a
// saturating count of stalled cycles.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no stall in progress; hazards evaluated every cycle
// ST_STALL | multi-cycle stall in progress; cnt_q = stall cycles left
module hazard_stall_ctrl #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_ex_memread,
    input  logic             id_ex_regwrite,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             ex_mem_memread,
    input  logic [REG_W-1:0] ex_mem_rd,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             flush,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    localparam logic [3:0]       LAT_N    = 4'(LOAD_LAT);
    localparam logic [3:0]       LAT_N1   = 4'(LOAD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q;

    logic             match_ex;
    logic             match_mem;
    logic             load_use_hz;
    logic             br_alu_hz;
    logic             br_exld_hz;
    logic             br_memld_hz;
    logic [3:0]       need_n;
    logic             stall_int;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    assign match_ex  = (id_ex_rd != '0) &
                       ((id_uses_rs & (id_ex_rd == if_id_rs)) |
                        (id_uses_rt & (id_ex_rd == if_id_rt)));
    assign match_mem = (ex_mem_rd != '0) &
                       ((id_uses_rs & (ex_mem_rd == if_id_rs)) |
                        (id_uses_rt & (ex_mem_rd == if_id_rt)));

    assign load_use_hz = id_ex_memread & match_ex;
    assign br_alu_hz   = id_is_branch & id_ex_regwrite & ~id_ex_memread & match_ex;
    assign br_exld_hz  = id_is_branch & id_ex_memread & match_ex;
    assign br_memld_hz = id_is_branch & ex_mem_memread & match_mem;

    // Bubble count is the max of the active terms; since LOAD_LAT >= 1 the
    // terms are ordered LOAD_LAT+1 > LOAD_LAT >= 1, so a priority chain is a max.
    always_comb begin
        need_n = 4'd0;
        if (br_exld_hz) begin
            need_n = LAT_N1;
        end else if (load_use_hz | br_memld_hz) begin
            need_n = LAT_N;
        end else if (br_alu_hz) begin
            need_n = 4'd1;
        end
    end

    // State and remaining-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: one stall cycle is issued from IDLE, the rest from STALL.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (stall_int && (need_n > 4'd1)) begin
                    state_d = ST_STALL;
                    cnt_d   = 3'(need_n - 4'd1);
                end
            end
            ST_STALL: begin
                if (flush) begin
                    // The stalled instruction is being discarded; nothing left to wait for.
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Output logic: Mealy stall in IDLE, unconditional stall in STALL, both killed by flush or reset.
    always_comb begin
        stall_int = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_IDLE:  stall_int = (need_n != 4'd0) & ~flush;
                ST_STALL: stall_int = ~flush;
                default:  stall_int = 1'b0;
            endcase
        end
        stall        = stall_int;
        pc_write     = ~stall_int;
        if_id_write  = ~stall_int;
        id_ex_bubble = stall_int;
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else if (stall_int && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_q <= stall_cycles_q + CNT_ONE;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: two instances (LOAD_LAT=1/CNT_W=16 and
// LOAD_LAT=3/CNT_W=4) share one set of inputs and are compared against a
// rule-level model of remaining stall cycles and stall counts.
module tb_hazard_stall_ctrl;

    localparam int REG_W = 5;
    localparam int LL_A  = 1;
    localparam int LL_B  = 3;
    localparam int CW_A  = 16;
    localparam int CW_B  = 4;
    localparam int MAX_A = (1 << CW_A) - 1;
    localparam int MAX_B = (1 << CW_B) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             id_ex_memread, id_ex_regwrite, ex_mem_memread;
    logic [REG_W-1:0] id_ex_rd, ex_mem_rd, if_id_rs, if_id_rt;
    logic             id_uses_rs, id_uses_rt, id_is_branch, flush;

    logic             a_pc_write, a_if_id_write, a_id_ex_bubble, a_stall;
    logic [CW_A-1:0]  a_stall_cycles;
    logic             b_pc_write, b_if_id_write, b_id_ex_bubble, b_stall;
    logic [CW_B-1:0]  b_stall_cycles;

    hazard_stall_ctrl #(.REG_W(REG_W), .LOAD_LAT(LL_A), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite), .id_ex_rd(id_ex_rd),
        .ex_mem_memread(ex_mem_memread), .ex_mem_rd(ex_mem_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
        .flush(flush),
        .pc_write(a_pc_write), .if_id_write(a_if_id_write), .id_ex_bubble(a_id_ex_bubble),
        .stall(a_stall), .stall_cycles(a_stall_cycles)
    );

    hazard_stall_ctrl #(.REG_W(REG_W), .LOAD_LAT(LL_B), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite), .id_ex_rd(id_ex_rd),
        .ex_mem_memread(ex_mem_memread), .ex_mem_rd(ex_mem_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
        .flush(flush),
        .pc_write(b_pc_write), .if_id_write(b_if_id_write), .id_ex_bubble(b_id_ex_bubble),
        .stall(b_stall), .stall_cycles(b_stall_cycles)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: stall cycles still owed and stall counts per instance.
    int rem_a = 0, rem_b = 0, sc_a = 0, sc_b = 0;
    bit exp_a, exp_b;
    int exp_sc_a, exp_sc_b;
    logic [3:0]      obs_a, obs_b;
    logic [CW_A-1:0] obs_sc_a;
    logic [CW_B-1:0] obs_sc_b;

    function automatic bit reads_reg(logic [REG_W-1:0] r);
        return (r != '0) && ((id_uses_rs && r == if_id_rs) || (id_uses_rt && r == if_id_rt));
    endfunction

    function automatic int bubbles_needed(int ll);
        int n = 0;
        if (id_ex_memread && reads_reg(id_ex_rd) && ll > n) n = ll;
        if (id_is_branch && id_ex_regwrite && !id_ex_memread && reads_reg(id_ex_rd) && 1 > n) n = 1;
        if (id_is_branch && id_ex_memread && reads_reg(id_ex_rd) && ll + 1 > n) n = ll + 1;
        if (id_is_branch && ex_mem_memread && reads_reg(ex_mem_rd) && ll > n) n = ll;
        return n;
    endfunction

    // {stall, pc_write, if_id_write, id_ex_bubble} for a given stall value
    function automatic logic [3:0] out_vec(bit s);
        return {s, ~s, ~s, s};
    endfunction

    // One clock: sample outputs mid-low-phase, predict, then advance the model at the edge.
    task automatic cycle();
        int na, nb;
        #1;
        if (!rst_n) begin
            rem_a = 0; rem_b = 0; sc_a = 0; sc_b = 0;
        end
        na = bubbles_needed(LL_A);
        nb = bubbles_needed(LL_B);
        exp_a = rst_n && ((rem_a > 0) ? !flush : (na != 0 && !flush));
        exp_b = rst_n && ((rem_b > 0) ? !flush : (nb != 0 && !flush));
        exp_sc_a = sc_a;
        exp_sc_b = sc_b;
        obs_a    = {a_stall, a_pc_write, a_if_id_write, a_id_ex_bubble};
        obs_b    = {b_stall, b_pc_write, b_if_id_write, b_id_ex_bubble};
        obs_sc_a = a_stall_cycles;
        obs_sc_b = b_stall_cycles;
        @(posedge clk);
        if (rst_n) begin
            if (exp_a && sc_a < MAX_A) sc_a++;
            if (exp_b && sc_b < MAX_B) sc_b++;
            if (rem_a > 0) rem_a = flush ? 0 : rem_a - 1;
            else if (exp_a) rem_a = na - 1;
            if (rem_b > 0) rem_b = flush ? 0 : rem_b - 1;
            else if (exp_b) rem_b = nb - 1;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        id_ex_memread = 0; id_ex_regwrite = 0; id_ex_rd = '0;
        ex_mem_memread = 0; ex_mem_rd = '0;
        if_id_rs = '0; if_id_rt = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_is_branch = 0; flush = 0;
    endtask

    task automatic idle(int n);
        clear_inputs();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        id_ex_memread = 1; id_ex_rd = 5'd2; if_id_rs = 5'd2; id_uses_rs = 1; id_is_branch = 1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (obs_a !== out_vec(1'b0) || obs_b !== out_vec(1'b0)) begin
                errors++;
                $display("FAIL reset_outputs: got a=%b b=%b want %b", obs_a, obs_b, out_vec(1'b0));
            end
            checks++;
            if (obs_sc_a !== '0 || obs_sc_b !== '0) begin
                errors++;
                $display("FAIL reset_counts: got a=%0d b=%0d want 0", obs_sc_a, obs_sc_b);
            end
        end
        rst_n = 1;
        clear_inputs();
        cycle();
        checks++;
        if (obs_a !== out_vec(1'b0) || obs_b !== out_vec(1'b0)) begin
            errors++;
            $display("FAIL reset_release: got a=%b b=%b want %b", obs_a, obs_b, out_vec(1'b0));
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        id_ex_memread = 1; id_ex_rd = 5'd2; if_id_rs = 5'd2; id_uses_rs = 1;
        cycle();
        checks++;
        if (obs_a !== out_vec(1'b1)) begin
            errors++;
            $display("FAIL load_use_stall: got %b want %b", obs_a, out_vec(1'b1));
        end
        checks++;
        if (obs_b !== out_vec(exp_b)) begin
            errors++;
            $display("FAIL load_use_b: got %b want %b", obs_b, out_vec(exp_b));
        end
        clear_inputs();
        ex_mem_memread = 1; ex_mem_rd = 5'd2; if_id_rs = 5'd2; id_uses_rs = 1;
        cycle();
        checks++;
        if (obs_a !== out_vec(1'b0)) begin
            errors++;
            $display("FAIL load_use_release: got %b want %b", obs_a, out_vec(1'b0));
        end
        checks++;
        if (obs_b !== out_vec(exp_b)) begin
            errors++;
            $display("FAIL load_use_b_hold: got %b want %b", obs_b, out_vec(exp_b));
        end
        idle(5);
    endtask

    task automatic test_branch_on_load();
        int base;
        clear_inputs();
        id_ex_memread = 1; id_ex_regwrite = 1; id_ex_rd = 5'd3;
        if_id_rt = 5'd3; id_uses_rt = 1; id_is_branch = 1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            if (i == 0) base = exp_sc_a;
            checks++;
            if (obs_a !== out_vec(1'b1)) begin
                errors++;
                $display("FAIL branch_load_c%0d: got %b want %b", i, obs_a, out_vec(1'b1));
            end
            checks++;
            if (obs_b !== out_vec(exp_b)) begin
                errors++;
                $display("FAIL branch_load_b_c%0d: got %b want %b", i, obs_b, out_vec(exp_b));
            end
        end
        clear_inputs();
        cycle();
        checks++;
        if (obs_a !== out_vec(1'b0)) begin
            errors++;
            $display("FAIL branch_load_end: got %b want %b", obs_a, out_vec(1'b0));
        end
        checks++;
        if (int'(obs_sc_a) !== base + 2) begin
            errors++;
            $display("FAIL branch_load_count: got %0d want %0d", obs_sc_a, base + 2);
        end
        checks++;
        if (obs_b !== out_vec(exp_b)) begin
            errors++;
            $display("FAIL branch_load_b_end: got %b want %b", obs_b, out_vec(exp_b));
        end
        idle(6);
    endtask

    task automatic test_reg_zero();
        clear_inputs();
        id_ex_memread = 1; id_ex_rd = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0;
        id_uses_rs = 1; id_uses_rt = 1; id_is_branch = 1;
        cycle();
        checks++;
        if (obs_a !== out_vec(1'b0) || obs_b !== out_vec(1'b0)) begin
            errors++;
            $display("FAIL reg_zero: got a=%b b=%b want %b", obs_a, obs_b, out_vec(1'b0));
        end
        clear_inputs();
        id_ex_memread = 1; id_ex_rd = 5'd5; if_id_rs = 5'd5; if_id_rt = 5'd5;
        cycle();
        checks++;
        if (obs_a !== out_vec(1'b0) || obs_b !== out_vec(1'b0)) begin
            errors++;
            $display("FAIL unused_operand: got a=%b b=%b want %b", obs_a, obs_b, out_vec(1'b0));
        end
        id_uses_rt = 1;
        cycle();
        checks++;
        if (obs_a !== out_vec(1'b1)) begin
            errors++;
            $display("FAIL used_rt_match: got %b want %b", obs_a, out_vec(1'b1));
        end
        idle(5);
    endtask

    task automatic test_flush();
        clear_inputs();
        id_ex_memread = 1; id_ex_rd = 5'd4; if_id_rs = 5'd4; id_uses_rs = 1;
        cycle();
        checks++;
        if (obs_b !== out_vec(1'b1)) begin
            errors++;
            $display("FAIL flush_first: got %b want %b", obs_b, out_vec(1'b1));
        end
        clear_inputs();
        flush = 1;
        cycle();
        checks++;
        if (obs_b !== out_vec(1'b0) || obs_a !== out_vec(1'b0)) begin
            errors++;
            $display("FAIL flush_abort: got a=%b b=%b want %b", obs_a, obs_b, out_vec(1'b0));
        end
        clear_inputs();
        cycle();
        checks++;
        if (obs_b !== out_vec(1'b0)) begin
            errors++;
            $display("FAIL flush_idle_after: got %b want %b", obs_b, out_vec(1'b0));
        end
        id_ex_memread = 1; id_ex_rd = 5'd4; if_id_rs = 5'd4; id_uses_rs = 1; flush = 1;
        cycle();
        checks++;
        if (obs_a !== out_vec(1'b0) || obs_b !== out_vec(1'b0)) begin
            errors++;
            $display("FAIL flush_in_idle: got a=%b b=%b want %b", obs_a, obs_b, out_vec(1'b0));
        end
        clear_inputs();
        cycle();
        checks++;
        if (obs_a !== out_vec(1'b0) || obs_b !== out_vec(1'b0)) begin
            errors++;
            $display("FAIL flush_in_idle_after: got a=%b b=%b want %b", obs_a, obs_b, out_vec(1'b0));
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        id_ex_memread = 1; id_ex_rd = 5'd6; if_id_rs = 5'd6; id_uses_rs = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (obs_a !== out_vec(1'b1) || obs_b !== out_vec(1'b1)) begin
                errors++;
                $display("FAIL back_to_back_c%0d: got a=%b b=%b want %b", i, obs_a, obs_b, out_vec(1'b1));
            end
        end
        clear_inputs();
        cycle();
        checks++;
        if (obs_a !== out_vec(1'b0) || obs_b !== out_vec(exp_b)) begin
            errors++;
            $display("FAIL back_to_back_end: got a=%b b=%b want a=%b b=%b",
                     obs_a, obs_b, out_vec(1'b0), out_vec(exp_b));
        end
        idle(5);
    endtask

    task automatic test_saturation();
        rst_n = 0;
        clear_inputs();
        cycle();
        rst_n = 1;
        id_ex_memread = 1; id_ex_rd = 5'd7; if_id_rt = 5'd7; id_uses_rt = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (obs_b !== out_vec(1'b1)) begin
                errors++;
                $display("FAIL sat_stall_c%0d: got %b want %b", i, obs_b, out_vec(1'b1));
            end
        end
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (obs_sc_b !== 4'd15) begin
                errors++;
                $display("FAIL sat_count_b_%0d: got %0d want 15", i, obs_sc_b);
            end
            checks++;
            if (obs_sc_a !== 16'd20) begin
                errors++;
                $display("FAIL sat_count_a_%0d: got %0d want 20", i, obs_sc_a);
            end
        end
        idle(4);
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        id_ex_memread = 1; id_ex_rd = 5'd2; if_id_rs = 5'd2; id_uses_rs = 1;
        cycle();
        rst_n = 0;
        cycle();
        checks++;
        if (obs_a !== out_vec(1'b0) || obs_b !== out_vec(1'b0)) begin
            errors++;
            $display("FAIL reset_mid_outputs: got a=%b b=%b want %b", obs_a, obs_b, out_vec(1'b0));
        end
        checks++;
        if (obs_sc_a !== '0 || obs_sc_b !== '0) begin
            errors++;
            $display("FAIL reset_mid_counts: got a=%0d b=%0d want 0", obs_sc_a, obs_sc_b);
        end
        rst_n = 1;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (obs_a !== out_vec(1'b0) || obs_b !== out_vec(1'b0)) begin
                errors++;
                $display("FAIL reset_mid_release_%0d: got a=%b b=%b want %b", i, obs_a, obs_b, out_vec(1'b0));
            end
        end
        id_ex_memread = 1; id_ex_rd = 5'd9; if_id_rt = 5'd9; id_uses_rt = 1;
        cycle();
        checks++;
        if (obs_a !== out_vec(1'b1) || obs_b !== out_vec(1'b1)) begin
            errors++;
            $display("FAIL reset_mid_new_hazard: got a=%b b=%b want %b", obs_a, obs_b, out_vec(1'b1));
        end
        idle(5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n          = ($urandom_range(0, 99) != 0);
            id_ex_memread  = 1'($urandom_range(0, 1));
            id_ex_regwrite = 1'($urandom_range(0, 1));
            id_ex_rd       = 5'($urandom_range(0, 3));
            ex_mem_memread = 1'($urandom_range(0, 1));
            ex_mem_rd      = 5'($urandom_range(0, 3));
            if_id_rs       = 5'($urandom_range(0, 3));
            if_id_rt       = 5'($urandom_range(0, 3));
            id_uses_rs     = 1'($urandom_range(0, 1));
            id_uses_rt     = 1'($urandom_range(0, 1));
            id_is_branch   = ($urandom_range(0, 2) == 0);
            flush          = ($urandom_range(0, 7) == 0);
            cycle();
            checks++;
            if (obs_a !== out_vec(exp_a)) begin
                errors++;
                $display("FAIL rand_a cyc %0d: got %b want %b", i, obs_a, out_vec(exp_a));
            end
            checks++;
            if (obs_b !== out_vec(exp_b)) begin
                errors++;
                $display("FAIL rand_b cyc %0d: got %b want %b", i, obs_b, out_vec(exp_b));
            end
            checks++;
            if (int'(obs_sc_a) !== exp_sc_a) begin
                errors++;
                $display("FAIL rand_count_a cyc %0d: got %0d want %0d", i, obs_sc_a, exp_sc_a);
            end
            checks++;
            if (int'(obs_sc_b) !== exp_sc_b) begin
                errors++;
                $display("FAIL rand_count_b cyc %0d: got %0d want %0d", i, obs_sc_b, exp_sc_b);
            end
        end
        rst_n = 1;
        idle(5);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_on_load();
        test_reg_zero();
        test_flush();
        test_back_to_back();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
